// File: rtl/trigger_host_endpoint_pkg.sv
// Shared uc bus field slices, trigger command codes and transmit FSM states
// for the host-side trigger endpoint.
package trigger_host_endpoint_pkg;

  localparam int TRIG_WIDTH = 8;

  // uc_in: bus driven toward the device
  localparam int UC_IN_WIDTH      = 32;
  localparam int UC_DATAOUT_START = 0;
  localparam int UC_DATAOUT_END   = 7;
  localparam int UC_CMD_START     = 8;
  localparam int UC_CMD_END       = 11;
  localparam int UC_ADDRESS_START = 12;
  localparam int UC_ADDRESS_END   = 23;
  localparam int UC_LENGTH_START  = 24;
  localparam int UC_LENGTH_END    = 31;

  // uc_out: bus driven by the device; only data and cmd are carried
  localparam int UC_OUT_WIDTH         = 12;
  localparam int UC_OUT_DATA_START    = 0;
  localparam int UC_OUT_DATA_END      = 7;
  localparam int UC_OUT_CMD_START     = 8;
  localparam int UC_OUT_CMD_END       = 11;

  localparam int UC_CMD_WIDTH = UC_CMD_END - UC_CMD_START + 1;

  localparam logic [UC_CMD_WIDTH-1:0] TRIGGER_IN_CMD  = 4'h6;
  localparam logic [UC_CMD_WIDTH-1:0] TRIGGER_OUT_CMD = 4'h7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_DRIVE = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_e;

  // TRIGGER_IN_CMD frame with zero address and length
  function automatic logic [UC_IN_WIDTH-1:0] trig_in_frame(input logic [TRIG_WIDTH-1:0] trig);
    logic [UC_IN_WIDTH-1:0] frame;
    frame = '0;
    frame[UC_DATAOUT_END:UC_DATAOUT_START] = trig;
    frame[UC_CMD_END:UC_CMD_START]         = TRIGGER_IN_CMD;
    return frame;
  endfunction

endpackage

// File: rtl/trigger_frame_rx.sv
// Receive path: decodes TRIGGER_OUT_CMD frames into sticky trigger flags,
// a frame counter, a new-frame pulse and an over-length error flag.
module trigger_frame_rx
  import trigger_host_endpoint_pkg::*;
#(
  parameter int MAX_FRAME_CYCLES = 15
) (
  input  logic                    uc_clk,
  input  logic                    uc_reset,
  input  logic [UC_OUT_WIDTH-1:0] uc_out_dev,
  input  logic [TRIG_WIDTH-1:0]   rx_clear,
  output logic [TRIG_WIDTH-1:0]   rx_status,
  output logic                    rx_event,
  output logic [7:0]              rx_frame_count,
  output logic                    rx_error
);

  localparam logic [3:0] LEN_MAX = 4'(MAX_FRAME_CYCLES);

  logic                  hit_s;
  logic                  rise_s;
  logic [TRIG_WIDTH-1:0] data_s;
  logic                  hit_d_r;
  logic [3:0]            len_r;

  assign hit_s  = (uc_out_dev[UC_OUT_CMD_END:UC_OUT_CMD_START] == TRIGGER_OUT_CMD);
  assign data_s = hit_s ? uc_out_dev[UC_OUT_DATA_END:UC_OUT_DATA_START] : 8'h00;
  assign rise_s = hit_s & ~hit_d_r;

  // Edge detect, sticky status, frame count and length check.
  // hit_d_r resets high so a frame already in progress at reset release is not counted.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      hit_d_r        <= 1'b1;
      len_r          <= 4'd0;
      rx_status      <= 8'h00;
      rx_event       <= 1'b0;
      rx_frame_count <= 8'h00;
      rx_error       <= 1'b0;
    end else begin
      hit_d_r   <= hit_s;
      rx_event  <= rise_s;
      rx_status <= (rx_status & ~rx_clear) | data_s;
      if (rise_s) begin
        rx_frame_count <= rx_frame_count + 8'd1;
      end else begin
        rx_frame_count <= rx_frame_count;
      end
      if (hit_s) begin
        len_r <= (len_r == 4'hF) ? 4'hF : (len_r + 4'd1);
      end else begin
        len_r <= 4'd0;
      end
      if (hit_s && (len_r >= LEN_MAX)) begin
        rx_error <= 1'b1;
      end else begin
        rx_error <= rx_error;
      end
    end
  end

endmodule

// File: rtl/trigger_host_endpoint.sv
// Host-side trigger endpoint: transmits TRIGGER_IN_CMD frames on uc_in and
// decodes TRIGGER_OUT_CMD frames from uc_out.
module trigger_host_endpoint
  import trigger_host_endpoint_pkg::*;
#(
  parameter int HOLD_CYCLES      = 4,
  parameter int GAP_CYCLES       = 2,
  parameter int MAX_FRAME_CYCLES = 15
) (
  input  logic                    uc_clk,
  input  logic                    uc_reset,
  output logic [UC_IN_WIDTH-1:0]  uc_in_host,
  input  logic [UC_OUT_WIDTH-1:0] uc_out_dev,
  input  logic [TRIG_WIDTH-1:0]   tx_trig,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [TRIG_WIDTH-1:0]   rx_status,
  input  logic [TRIG_WIDTH-1:0]   rx_clear,
  output logic                    rx_event,
  output logic [7:0]              rx_frame_count,
  output logic                    rx_error
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  logic [1:0]             rst_sync_r;
  logic                   rst_n_s;
  tx_state_e              state_r;
  tx_state_e              state_nxt_s;
  logic [3:0]             cnt_r;
  logic [3:0]             cnt_nxt_s;
  logic [UC_IN_WIDTH-1:0] frame_nxt_s;
  logic                   ready_nxt_s;

  // Reset synchronizer: asynchronous assertion, release aligned to uc_clk
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Transmit FSM state and registered bus/ready outputs
  always_ff @(posedge uc_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r    <= TX_IDLE;
      cnt_r      <= 4'd0;
      uc_in_host <= '0;
      tx_ready   <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      uc_in_host <= frame_nxt_s;
      tx_ready   <= ready_nxt_s;
    end
  end

  // Next state and next registered outputs; the frame register itself holds the latched bits
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    frame_nxt_s = uc_in_host;
    ready_nxt_s = tx_ready;
    case (state_r)
      TX_IDLE: begin
        ready_nxt_s = 1'b1;
        frame_nxt_s = '0;
        if (tx_valid && (tx_trig != 8'h00)) begin
          state_nxt_s = TX_DRIVE;
          cnt_nxt_s   = 4'd0;
          frame_nxt_s = trig_in_frame(tx_trig);
          ready_nxt_s = 1'b0;
        end else begin
          state_nxt_s = TX_IDLE;
        end
      end
      TX_DRIVE: begin
        if (cnt_r == HOLD_LAST) begin
          state_nxt_s = TX_GAP;
          cnt_nxt_s   = 4'd0;
          frame_nxt_s = '0;
        end else begin
          cnt_nxt_s   = cnt_r + 4'd1;
        end
      end
      TX_GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_nxt_s = TX_IDLE;
          cnt_nxt_s   = 4'd0;
          ready_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s = TX_IDLE;
        cnt_nxt_s   = 4'd0;
        frame_nxt_s = '0;
        ready_nxt_s = 1'b1;
      end
    endcase
  end

  trigger_frame_rx #(
    .MAX_FRAME_CYCLES(MAX_FRAME_CYCLES)
  ) u_rx (
    .uc_clk        (uc_clk),
    .uc_reset      (rst_n_s),
    .uc_out_dev    (uc_out_dev),
    .rx_clear      (rx_clear),
    .rx_status     (rx_status),
    .rx_event      (rx_event),
    .rx_frame_count(rx_frame_count),
    .rx_error      (rx_error)
  );

endmodule
